// File: rtl/booth_mult_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mult_arb_pkg
//   Shared widths, operand/product types and a small round-robin helper for
//   the shared Booth multiplier arbiter and its sub-modules.
//   Contents:
//     DATA_W      operand width (fixed by the Booth multiplier)
//     PROD_W      full-precision product width (2*DATA_W)
//     operand_t   signed DATA_W-bit operand
//     product_t   signed PROD_W-bit product
//     wrap_inc()  next round-robin pointer after a winner index
// ---------------------------------------------------------------------------
package mult_arb_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [PROD_W-1:0] product_t;

  // The winner becomes lowest priority: the scan restarts one slot past it.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_booth.sv
// ---------------------------------------------------------------------------
// Booth_Multiplier_Synth
//   Combinational radix-4 Booth multiplier, signed DATA_W x DATA_W -> PROD_W,
//   full precision with no rounding or saturation.
//   Ports:
//     multiplicand_i  operand_t  signed multiplicand a
//     multiplier_i    operand_t  signed multiplier b
//     product_o       product_t  signed product a*b
// ---------------------------------------------------------------------------
module Booth_Multiplier_Synth
  import mult_arb_pkg::*;
(
  input  operand_t multiplicand_i,
  input  operand_t multiplier_i,
  output product_t product_o
);

  product_t        a_ext;
  logic [DATA_W:0] b_ext;
  product_t        pp;
  product_t        acc;

  assign a_ext = {{(PROD_W - DATA_W){multiplicand_i[DATA_W-1]}}, multiplicand_i};
  // Implicit zero below the LSB of b, so every digit sees a 3-bit window.
  assign b_ext = {multiplier_i, 1'b0};

  // Each overlapping 3-bit window of b recodes to a digit in {-2,-1,0,+1,+2};
  // the partial products are summed modulo 2^PROD_W, which is exact because
  // the true product always fits in PROD_W signed bits.
  always_comb begin
    pp  = '0;
    acc = '0;
    for (int i = 0; i < DATA_W / 2; i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * i));
    end
  end

  assign product_o = acc;

endmodule

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Scans the request vector starting at
//   ptr_i and wrapping from N-1 back to 0; the first asserted request wins.
//   Ports:
//     req_i        [N-1:0]   request vector
//     ptr_i        [IW-1:0]  index with highest priority this cycle
//     grant_o      [N-1:0]   one-hot grant (all zero if no request)
//     grant_idx_o  [IW-1:0]  binary index of the granted request
//     any_o                  at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);

  // Only the first hit in the rotated order is taken, so the grant stays
  // one-hot even when several requests are pending.
  always_comb begin : scan
    int cand;
    cand        = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mult_arbiter
//   Shares one Booth_Multiplier_Synth between NUM_REQ requesters with a
//   round-robin grant and valid/ready handshakes on both sides. Two-stage
//   pipeline (operand register S1 -> multiplier -> result register S2),
//   one product per cycle, responses tagged with the issuing requester id.
//   Ports:
//     clk           system clock, rising edge
//     rst_n         asynchronous active-low reset
//     req_valid     per-requester operand valid
//     req_a/req_b   packed operands, slot i = [i*DATA_W +: DATA_W]
//     req_ready     one-hot grant; transfer = req_valid[i] & req_ready[i]
//     resp_valid    result register holds a product
//     resp_id       requester index of the product
//     resp_product  signed product a*b
//     resp_ready    consumer accepts the response this cycle
//     busy          either pipeline stage holds data
// ---------------------------------------------------------------------------
module booth_mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        resp_valid,
  output logic [ID_W-1:0]             resp_id,
  output product_t                    resp_product,
  input  logic                        resp_ready,
  output logic                        busy
);

  logic      s1_valid_q, s1_valid_d;
  operand_t  s1_a_q, s1_a_d;
  operand_t  s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  logic      s2_valid_q, s2_valid_d;
  product_t  s2_prod_q, s2_prod_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  logic     adv1, adv2, s1_free, s2_free, accept;
  product_t mult_product;

  // A stage can take new data when empty or when its content leaves this
  // same cycle; that chaining is what gives full rate without bubbles.
  assign adv2    = s2_valid_q & resp_ready;
  assign s2_free = ~s2_valid_q | adv2;
  assign adv1    = s1_valid_q & s2_free;
  assign s1_free = ~s1_valid_q | adv1;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  // rst_n gates the grant so nothing is offered while reset is held.
  assign accept    = rst_n & s1_free & arb_any;
  assign req_ready = accept ? arb_grant : '0;

  Booth_Multiplier_Synth u_mult (
    .multiplicand_i (s1_a_q),
    .multiplier_i   (s1_b_q),
    .product_o      (mult_product)
  );

  // Next-state for both pipeline stages and the round-robin pointer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[int'(arb_idx)*DATA_W +: DATA_W];
      s1_b_d     = req_b[int'(arb_idx)*DATA_W +: DATA_W];
      s1_id_d    = arb_idx;
      rr_ptr_d   = ID_W'(wrap_inc(32'(arb_idx), NUM_REQ));
    end else if (adv1) begin
      s1_valid_d = 1'b0;
    end

    if (adv1) begin
      s2_valid_d = 1'b1;
      s2_prod_d  = mult_product;
      s2_id_d    = s1_id_q;
    end else if (adv2) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign resp_valid   = s2_valid_q;
  assign resp_id      = s2_id_q;
  assign resp_product = s2_prod_q;
  assign busy         = s1_valid_q | s2_valid_q;

endmodule
